// File: rtl/morph_pkg.sv
// Shared encodings for the binary morphology filter: frame modes,
// per-stage operations and the mode-to-operation mapping.
package morph_pkg;

    localparam logic [2:0] MODE_BYPASS = 3'd0;
    localparam logic [2:0] MODE_ERODE  = 3'd1;
    localparam logic [2:0] MODE_DILATE = 3'd2;
    localparam logic [2:0] MODE_OPEN   = 3'd3;
    localparam logic [2:0] MODE_CLOSE  = 3'd4;

    localparam int STAGE_LAT = 3;

    typedef enum logic [1:0] {
        OP_PASS   = 2'd0,
        OP_ERODE  = 2'd1,
        OP_DILATE = 2'd2
    } op_e;

    typedef struct packed {
        op_e op0;
        op_e op1;
    } ops_t;

    function automatic ops_t mode_to_ops(input logic [2:0] mode);
        ops_t o;
        o.op0 = OP_PASS;
        o.op1 = OP_PASS;
        case (mode)
            MODE_ERODE:  o.op0 = OP_ERODE;
            MODE_DILATE: o.op0 = OP_DILATE;
            MODE_OPEN: begin
                o.op0 = OP_ERODE;
                o.op1 = OP_DILATE;
            end
            MODE_CLOSE: begin
                o.op0 = OP_DILATE;
                o.op1 = OP_ERODE;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/morph_3x3_stage.sv
// One 3x3 binary morphology stage: two line buffers, stream counters,
// window with neutral-tap padding, op mux and a matching sync delay line.
module morph_3x3_stage
    import morph_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int CW        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] op,
    input  logic       vsync,
    input  logic       href,
    input  logic       clken,
    input  logic       din,
    output logic       post_vsync,
    output logic       post_href,
    output logic       post_clken,
    output logic       post_bit,
    output logic       line_bad
);

    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam logic [CW-1:0] HMAX = CW'(IMG_HDISP);
    localparam logic [CW-1:0] VMAX = CW'(IMG_VDISP);

    logic lb1 [IMG_HDISP];
    logic lb2 [IMG_HDISP];

    logic [CW-1:0]        col, row;
    logic                 vs_d, hs_d;
    logic [2:0]           c0, c1, c2;
    logic                 b1, res, pix_q;
    logic [STAGE_LAT-1:0] vs_p, hs_p, ck_p;

    logic          en, in_range, vs_rise, hs_fall;
    logic          neutral, r1, r2;
    logic [AW-1:0] idx;
    logic [8:0]    win;

    assign en       = href & clken;
    assign in_range = col < HMAX;
    assign vs_rise  = vsync & ~vs_d;
    assign hs_fall  = hs_d & ~href;
    assign neutral  = (op == OP_ERODE);
    assign idx      = col[AW-1:0];
    assign win      = {c2, c1, c0};
    assign line_bad = hs_fall && (col != HMAX);

    // Rows above the frame top read the neutral element, never stale data.
    assign r1 = (in_range && row >= CW'(1)) ? lb1[idx] : neutral;
    assign r2 = (in_range && row >= CW'(2)) ? lb2[idx] : neutral;

    always_ff @(posedge clk) begin
        if (en && in_range) begin
            lb1[idx] <= din;
            lb2[idx] <= lb1[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
            hs_d <= 1'b0;
            col  <= '0;
            row  <= '0;
        end else begin
            vs_d <= vsync;
            hs_d <= href;
            if (vs_rise)
                row <= '0;
            else if (hs_fall && row != VMAX)
                row <= row + CW'(1);
            if (hs_fall)
                col <= '0;
            else if (en && col != '1)
                col <= col + CW'(1);
        end
    end

    // Older columns left of the frame edge are replaced by neutral taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0 <= '0;
            c1 <= '0;
            c2 <= '0;
        end else if (en) begin
            c0 <= {r2, r1, din};
            c1 <= (col == '0) ? {3{neutral}} : c0;
            c2 <= (col <= CW'(1)) ? {3{neutral}} : c1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1    <= 1'b0;
            res   <= 1'b0;
            pix_q <= 1'b0;
            vs_p  <= '0;
            hs_p  <= '0;
            ck_p  <= '0;
        end else begin
            b1 <= din;
            case (op)
                OP_ERODE:  res <= &win;
                OP_DILATE: res <= |win;
                default:   res <= b1;
            endcase
            pix_q <= res;
            vs_p  <= {vs_p[STAGE_LAT-2:0], vsync};
            hs_p  <= {hs_p[STAGE_LAT-2:0], href};
            ck_p  <= {ck_p[STAGE_LAT-2:0], clken};
        end
    end

    assign post_vsync = vs_p[STAGE_LAT-1];
    assign post_href  = hs_p[STAGE_LAT-1];
    assign post_clken = ck_p[STAGE_LAT-1];
    assign post_bit   = pix_q;

endmodule

// File: rtl/morph_filter.sv
// Runtime-configurable binary morphology: per-frame mode latch, two
// cascaded 3x3 stages and a sticky per-frame line-length error flag.
module morph_filter
    import morph_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int CW        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] cfg_mode,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic       per_img_Bit,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit,
    output logic [2:0] mode_active,
    output logic       line_len_err
);

    logic       vs_d, vs_rise, err_q;
    logic [2:0] mode_q;
    ops_t       ops;
    logic       s0_vs, s0_hs, s0_ck, s0_bit;
    logic       bad0, unused_bad1;

    assign vs_rise = per_frame_vsync & ~vs_d;
    assign ops     = mode_to_ops(mode_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d   <= 1'b0;
            mode_q <= MODE_BYPASS;
            err_q  <= 1'b0;
        end else begin
            vs_d <= per_frame_vsync;
            if (vs_rise) begin
                mode_q <= (cfg_mode > MODE_CLOSE) ? MODE_BYPASS : cfg_mode;
                err_q  <= 1'b0;
            end else if (bad0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mode_active  = mode_q;
    assign line_len_err = err_q;

    morph_3x3_stage #(
        .IMG_HDISP(IMG_HDISP),
        .IMG_VDISP(IMG_VDISP),
        .CW       (CW)
    ) u_stage0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (ops.op0),
        .vsync     (per_frame_vsync),
        .href      (per_frame_href),
        .clken     (per_frame_clken),
        .din       (per_img_Bit),
        .post_vsync(s0_vs),
        .post_href (s0_hs),
        .post_clken(s0_ck),
        .post_bit  (s0_bit),
        .line_bad  (bad0)
    );

    // Stage 1 sees the same line lengths three clocks later; its flag is redundant.
    morph_3x3_stage #(
        .IMG_HDISP(IMG_HDISP),
        .IMG_VDISP(IMG_VDISP),
        .CW       (CW)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (ops.op1),
        .vsync     (s0_vs),
        .href      (s0_hs),
        .clken     (s0_ck),
        .din       (s0_bit),
        .post_vsync(post_frame_vsync),
        .post_href (post_frame_href),
        .post_clken(post_frame_clken),
        .post_bit  (post_img_Bit),
        .line_bad  (unused_bad1)
    );

endmodule

// File: tb/tb_morph_filter.sv
// Directed self-checking bench for morph_filter on an 8x6 image.
module tb_morph_filter;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cfg_mode;
    logic       vsync, href, clken, pix;
    logic       post_frame_vsync, post_frame_href, post_frame_clken;
    logic       post_img_Bit;
    logic [2:0] mode_active;
    logic       line_len_err;

    always #5 clk = ~clk;

    morph_filter #(
        .IMG_HDISP(W),
        .IMG_VDISP(H),
        .CW       (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_mode        (cfg_mode),
        .per_frame_vsync (vsync),
        .per_frame_href  (href),
        .per_frame_clken (clken),
        .per_img_Bit     (pix),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .post_img_Bit    (post_img_Bit),
        .mode_active     (mode_active),
        .line_len_err    (line_len_err)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] img [H];
    logic [W-1:0] cap [H];
    int           ox, oy, npix;
    logic         pv_d = 1'b0;
    logic         ph_d = 1'b0;

    // Records the output stream by position; no checking here.
    always @(posedge clk) begin
        #1;
        if (post_frame_vsync && !pv_d) begin
            ox = 0;
            oy = 0;
            npix = 0;
            for (int y = 0; y < H; y++) cap[y] = '0;
        end
        if (post_frame_href && post_frame_clken) begin
            if (ox < W && oy < H) cap[oy][ox] = post_img_Bit;
            ox++;
            npix++;
        end
        if (!post_frame_href && ph_d) begin
            oy++;
            ox = 0;
        end
        pv_d = post_frame_vsync;
        ph_d = post_frame_href;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_img();
        for (int y = 0; y < H; y++) img[y] = '0;
    endtask

    task automatic send_line(input int y, input int len, input bit gaps);
        for (int x = 0; x < len; x++) begin
            href  = 1'b1;
            clken = 1'b1;
            pix   = (x < W) ? img[y][x] : 1'b1;
            tick();
            if (gaps && (x % 3 == 1)) begin
                clken = 1'b0;
                pix   = 1'b1;
                tick();
            end
        end
        href  = 1'b0;
        clken = 1'b0;
        pix   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick();
        tick();
    endtask

    task automatic frame_end();
        tick();
        vsync = 1'b0;
        repeat (10) tick();
    endtask

    task automatic send_frame(input bit gaps);
        frame_start();
        for (int y = 0; y < H; y++) send_line(y, W, gaps);
        frame_end();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_mode = 3'd0;
        vsync = 0; href = 0; clken = 0; pix = 0;
        tick();
        checks++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit} !== 4'b0) begin
            errors++;
            $display("FAIL reset_stream: got %b want 0000",
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit});
        end
        checks++;
        if ({mode_active, line_len_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_mode_err: got mode=%0d err=%b want 0/0", mode_active, line_len_err);
        end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_bypass();
        logic [3:0] q [128];
        logic [3:0] got;
        cfg_mode = 3'd0;
        for (int i = 0; i < 128; i++) begin
            vsync = (i >= 4 && i < 116);
            href  = vsync && (i % 12 < 9);
            clken = 1'($urandom_range(0, 1));
            pix   = 1'($urandom_range(0, 1));
            q[i]  = {vsync, href, clken, pix};
            tick();
            // The value taken at one edge leaves the sixth register five edges later.
            if (i >= 5) begin
                got = {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit};
                checks++;
                if (got !== q[i-5]) begin
                    errors++;
                    $display("FAIL bypass_delay cyc %0d: got %b want %b", i, got, q[i-5]);
                end
            end
        end
        vsync = 0; href = 0; clken = 0; pix = 0;
        repeat (10) tick();
    endtask

    task automatic test_erode();
        cfg_mode = 3'd1;
        clear_img();
        img[3][3] = 1'b1;
        send_frame(1'b0);
        checks++;
        if (mode_active !== 3'd1) begin
            errors++;
            $display("FAIL erode_mode: got %0d want 1", mode_active);
        end
        for (int y = 0; y < H; y++) begin
            checks++;
            if (cap[y] !== 8'h00) begin
                errors++;
                $display("FAIL erode_single row %0d: got %b want 00000000", y, cap[y]);
            end
        end
        for (int y = 0; y < H; y++) img[y] = '1;
        send_frame(1'b0);
        for (int y = 0; y < H; y++) begin
            checks++;
            if (cap[y] !== 8'hFF) begin
                errors++;
                $display("FAIL erode_ones row %0d: got %b want 11111111", y, cap[y]);
            end
        end
    endtask

    task automatic test_dilate();
        int ones;
        logic want;
        cfg_mode = 3'd2;
        clear_img();
        img[3][3] = 1'b1;
        send_frame(1'b1);
        ones = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                want = (x >= 3 && x <= 5 && y >= 3 && y <= 5);
                ones += int'(cap[y][x]);
                checks++;
                if (cap[y][x] !== want) begin
                    errors++;
                    $display("FAIL dilate px(%0d,%0d): got %b want %b", x, y, cap[y][x], want);
                end
            end
        checks++;
        if (ones != 9 || npix != W * H) begin
            errors++;
            $display("FAIL dilate_count: got ones=%0d pix=%0d want 9/%0d", ones, npix, W * H);
        end
    endtask

    task automatic test_open_close();
        logic want;
        cfg_mode = 3'd3;
        clear_img();
        img[2][2] = 1'b1;
        for (int y = 2; y <= 4; y++)
            for (int x = 4; x <= 6; x++) img[y][x] = 1'b1;
        send_frame(1'b0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                want = (x >= 6 && y >= 4);
                checks++;
                if (cap[y][x] !== want) begin
                    errors++;
                    $display("FAIL open px(%0d,%0d): got %b want %b", x, y, cap[y][x], want);
                end
            end
        // Closing a lone pixel: the 3x3 dilation erodes back to one point at (5,5).
        cfg_mode = 3'd4;
        clear_img();
        img[3][3] = 1'b1;
        send_frame(1'b0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                want = (x == 5 && y == 5);
                checks++;
                if (cap[y][x] !== want) begin
                    errors++;
                    $display("FAIL close px(%0d,%0d): got %b want %b", x, y, cap[y][x], want);
                end
            end
    endtask

    task automatic test_mode_change();
        logic want;
        cfg_mode = 3'd1;
        clear_img();
        img[3][3] = 1'b1;
        frame_start();
        for (int y = 0; y < 3; y++) send_line(y, W, 1'b0);
        cfg_mode = 3'd2;
        for (int y = 3; y < H; y++) send_line(y, W, 1'b0);
        checks++;
        if (mode_active !== 3'd1) begin
            errors++;
            $display("FAIL mode_hold: got %0d want 1", mode_active);
        end
        frame_end();
        for (int y = 0; y < H; y++) begin
            checks++;
            if (cap[y] !== 8'h00) begin
                errors++;
                $display("FAIL mode_old_frame row %0d: got %b want 00000000", y, cap[y]);
            end
        end
        frame_start();
        checks++;
        if (mode_active !== 3'd2) begin
            errors++;
            $display("FAIL mode_next: got %0d want 2", mode_active);
        end
        for (int y = 0; y < H; y++) send_line(y, W, 1'b0);
        frame_end();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                want = (x >= 3 && x <= 5 && y >= 3 && y <= 5);
                checks++;
                if (cap[y][x] !== want) begin
                    errors++;
                    $display("FAIL mode_new_frame px(%0d,%0d): got %b want %b",
                             x, y, cap[y][x], want);
                end
            end
    endtask

    task automatic test_line_len();
        cfg_mode = 3'd0;
        clear_img();
        frame_start();
        send_line(0, W, 1'b0);
        send_line(1, W, 1'b0);
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_clean_lines: got %b want 0", line_len_err);
        end
        send_line(2, 7, 1'b0);
        checks++;
        if (line_len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_short_line: got %b want 1", line_len_err);
        end
        for (int y = 3; y < H; y++) send_line(y, W, 1'b0);
        frame_end();
        checks++;
        if (line_len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_sticky: got %b want 1", line_len_err);
        end
        frame_start();
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_clear_on_vsync: got %b want 0", line_len_err);
        end
        for (int y = 0; y < H; y++) send_line(y, (y == 4) ? W + 1 : W, 1'b0);
        frame_end();
        checks++;
        if (line_len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_long_line: got %b want 1", line_len_err);
        end
        frame_start();
        frame_end();
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_empty_frame: got %b want 0", line_len_err);
        end
        send_frame(1'b0);
        checks++;
        if (line_len_err !== 1'b0) begin
            errors++;
            $display("FAIL len_clean_frame: got %b want 0", line_len_err);
        end
    endtask

    task automatic test_reset_mid();
        logic want;
        cfg_mode = 3'd2;
        for (int y = 0; y < H; y++) img[y] = '1;
        frame_start();
        send_line(0, W, 1'b0);
        send_line(1, W, 1'b0);
        href = 1'b1;
        clken = 1'b1;
        pix = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
             mode_active, line_len_err} !== 8'b0) begin
            errors++;
            $display("FAIL reset_async: got %b want 00000000",
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
                      mode_active, line_len_err});
        end
        vsync = 0; href = 0; clken = 0; pix = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_img();
        img[3][3] = 1'b1;
        send_frame(1'b0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                want = (x >= 3 && x <= 5 && y >= 3 && y <= 5);
                checks++;
                if (cap[y][x] !== want) begin
                    errors++;
                    $display("FAIL reset_next_frame px(%0d,%0d): got %b want %b",
                             x, y, cap[y][x], want);
                end
            end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_erode();
        test_dilate();
        test_open_close();
        test_mode_change();
        test_line_len();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
